// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predict unit.
//   - opcode[3:2] encodings that tell B-type, JALR and JAL apart
//   - B-type funct3 condition codes
//   - 2-bit saturating counter states and the step function
//   - the control half of the one-stage training request
package bpu_pkg;

    localparam logic [1:0] OPJ_B    = 2'b00;
    localparam logic [1:0] OPJ_JALR = 2'b01;
    localparam logic [1:0] OPJ_JAL  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Training request control. Index, tag and target live in separate
    // registers because their widths depend on the top-level parameters.
    typedef struct packed {
        logic       valid;   // request pending for the next edge
        logic       wr_all;  // taken: write valid/tag/target/uncond
        logic       wr_ctr;  // write the counter field
        logic       uncond;  // JAL/JALR
        logic [1:0] ctr;     // counter value to store
    } upd_req_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != CTR_ST) n = c + 2'd1;
        else if (!taken && c != CTR_SNT) n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator.
//   opcode_j_i : opcode[3:2]; anything other than B-type is always taken
//   funct3_i   : B-type condition
//   a_i, b_i   : forwarded rs1/rs2 operands
//   taken_o    : actual branch outcome
module branch_cmp
    import bpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      opcode_j_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            taken_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a_i == b_i);
    assign lt  = ($signed(a_i) < $signed(b_i));
    assign ltu = (a_i < b_i);

    always_comb begin
        taken_o = 1'b0;
        if (opcode_j_i != OPJ_B) begin
            taken_o = 1'b1;
        end else begin
            case (funct3_i)
                F3_BEQ:  taken_o = eq;
                F3_BNE:  taken_o = !eq;
                F3_BLT:  taken_o = lt;
                F3_BGE:  taken_o = !lt;
                F3_BLTU: taken_o = ltu;
                F3_BGEU: taken_o = !ltu;
                default: taken_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor (IF) and resolver (ID).
//   IF : if_pc -> if_pred_taken / if_pred_target from a direct-mapped BTB
//        with 2-bit counters, combinational lookup.
//   ID : id_* resolve B/JAL/JALR, compare against the carried prediction,
//        drive redirect/redirect_addr/flush on mispredict only.
//   Training goes through one update register: resolve in R, table write at
//   the end of R+1, no bypass. stat_* are saturating event counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [XLEN-1:0]   if_pred_target,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic              id_ctrl_branch,
    input  logic [1:0]        id_opcode_j,
    input  logic [2:0]        id_funct3,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imme,
    input  logic              id_pred_taken,
    input  logic [XLEN-1:0]   id_pred_target,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_addr,
    output logic              flush,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // BTB and counters as flop arrays so lookup stays asynchronous.
    logic             valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]  tgt_q    [BTB_DEPTH];
    logic             uncond_q [BTB_DEPTH];
    logic [1:0]       ctr_q    [BTB_DEPTH];

    upd_req_t         upd_d, upd_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [TAG_W-1:0] upd_tag_q;
    logic [XLEN-1:0]  upd_tgt_q;

    logic [STAT_W-1:0] stat_br_q, stat_mp_q;

    // Fetch-side lookup.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign if_tag         = if_pc[XLEN-1:IDX_W+2];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && (uncond_q[if_idx] || ctr_q[if_idx][1]);
    assign if_pred_target = if_hit ? tgt_q[if_idx] : '0;

    // Decode-side resolution.
    logic             res;
    logic             actual_taken;
    logic [XLEN-1:0]  jalr_sum, pc_sum, pc_plus4, actual_target;
    logic             mispredict;
    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit;

    assign res = id_valid && !id_stall && id_ctrl_branch;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .opcode_j_i (id_opcode_j),
        .funct3_i   (id_funct3),
        .a_i        (id_rdata1),
        .b_i        (id_rdata2),
        .taken_o    (actual_taken)
    );

    assign jalr_sum      = id_rdata1 + id_imme;
    assign pc_sum        = id_pc + id_imme;
    assign pc_plus4      = id_pc + XLEN'(4);
    assign actual_target = (id_opcode_j == OPJ_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;

    assign mispredict = (actual_taken != id_pred_taken) ||
                        (actual_taken && id_pred_taken && (actual_target != id_pred_target));

    assign redirect      = res && mispredict;
    assign flush         = redirect;
    assign redirect_addr = redirect ? (actual_taken ? actual_target : pc_plus4) : '0;

    // Training request, computed from the table as it stands in R.
    assign id_idx = id_pc[IDX_W+1:2];
    assign id_tag = id_pc[XLEN-1:IDX_W+2];
    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    always_comb begin
        upd_d        = '0;
        upd_d.valid  = res;
        upd_d.wr_all = actual_taken;
        upd_d.wr_ctr = actual_taken || id_hit;
        upd_d.uncond = (id_opcode_j != OPJ_B);
        // A fresh allocation or tag replacement starts weakly taken.
        upd_d.ctr    = (actual_taken && !id_hit) ? CTR_WT : ctr_next(ctr_q[id_idx], actual_taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q     <= '0;
            upd_idx_q <= '0;
            upd_tag_q <= '0;
            upd_tgt_q <= '0;
        end else begin
            upd_q <= upd_d;
            if (res) begin
                upd_idx_q <= id_idx;
                upd_tag_q <= id_tag;
                upd_tgt_q <= actual_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                tgt_q[i]    <= '0;
                uncond_q[i] <= 1'b0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_q.valid) begin
            if (upd_q.wr_all) begin
                valid_q[upd_idx_q]  <= 1'b1;
                tag_q[upd_idx_q]    <= upd_tag_q;
                tgt_q[upd_idx_q]    <= upd_tgt_q;
                uncond_q[upd_idx_q] <= upd_q.uncond;
            end
            if (upd_q.wr_ctr) begin
                ctr_q[upd_idx_q] <= upd_q.ctr;
            end
        end
    end

    // Statistics hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (res && stat_br_q != '1) stat_br_q <= stat_br_q + 1'b1;
            if (redirect && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 1'b1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    // Byte-offset bits never select anything.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

endmodule
